response_framer: RTL and testbench

- Transmit-side counterpart of the command interpreter: packs one processor-ci controller response (opcode echo, optional 32-bit payload) into a byte frame.
- Streams the frame to the UART transmitter over a valid/ready byte handshake.
- Sits between the interpreter's result path (ALU result, register/memory reads) and the UART TX.
- Frame format: SYNC, OPCODE, [D3 D2 D1 D0], CHECK.
  - Payload is sent MSB first.
  - CHECK = XOR of OPCODE and all payload bytes; SYNC is excluded.

---
 rtl/response_framer_pkg.sv | 35 +++
 rtl/response_framer_if.sv | 22 ++
 rtl/response_framer.sv | 128 ++++++++++++
 tb/tb_response_framer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/response_framer_pkg.sv
// rtl/response_framer_pkg.sv - shared controller constants, framer state encoding and byte helper
package response_framer_pkg;

    // Interpreter command encoding; the framer echoes these back verbatim.
    localparam logic [7:0] OP_IDLE                 = 8'h00;
    localparam logic [7:0] OP_ESCREVER_UART        = 8'h01;
    localparam logic [7:0] OP_RESET_PROCESSADOR    = 8'h02;
    localparam logic [7:0] OP_LER_RESULTADO_ALU    = 8'h03;
    localparam logic [7:0] OP_LER_REGISTRADOR      = 8'h04;
    localparam logic [7:0] OP_ESCREVER_REGISTRADOR = 8'h05;
    localparam logic [7:0] OP_LER_MEMORIA          = 8'h06;
    localparam logic [7:0] OP_ESCREVER_MEMORIA     = 8'h07;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_SYNC  = 3'd1,
        ST_SEND_OP    = 3'd2,
        ST_SEND_DATA  = 3'd3,
        ST_SEND_CHECK = 3'd4
    } framer_state_e;

    function automatic logic [7:0] payload_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/response_framer_if.sv
// rtl/response_framer_if.sv - response intake and TX byte stream handshakes
interface response_framer_if;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_opcode;
    logic        resp_has_data;
    logic [31:0] resp_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    // master: interpreter + UART TX side; slave: the framer itself
    modport master (
        output resp_valid, resp_opcode, resp_has_data, resp_data, tx_ready,
        input  resp_ready, tx_valid, tx_data
    );

    modport slave (
        input  resp_valid, resp_opcode, resp_has_data, resp_data, tx_ready,
        output resp_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/response_framer.sv
// rtl/response_framer.sv - packs one controller response into SYNC/OPCODE/[DATA]/CHECK bytes
module response_framer
    import response_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter int         DATA_BYTES = 4
) (
    input  logic               clk,
    input  logic               reset,
    response_framer_if.slave   bus,
    output logic               busy,
    output logic [15:0]        frame_count
);

    localparam logic [1:0] LAST_IDX = 2'(DATA_BYTES - 1);

    framer_state_e state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic          has_data_q, has_data_d;
    logic [31:0]   data_q, data_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    check_q, check_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          tx_xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            opcode_q      <= 8'h00;
            has_data_q    <= 1'b0;
            data_q        <= 32'h0;
            idx_q         <= 2'd0;
            check_q       <= 8'h00;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            frame_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            has_data_q    <= has_data_d;
            data_q        <= data_d;
            idx_q         <= idx_d;
            check_q       <= check_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    // The next byte is always computed one cycle early so tx_data is a flop output.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        has_data_d    = has_data_q;
        data_d        = data_q;
        idx_d         = idx_q;
        check_d       = check_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        frame_count_d = frame_count_q;
        tx_xfer       = tx_valid_q && bus.tx_ready;

        case (state_q)
            ST_IDLE: begin
                if (bus.resp_valid) begin
                    opcode_d   = bus.resp_opcode;
                    has_data_d = bus.resp_has_data;
                    data_d     = bus.resp_data;
                    check_d    = bus.resp_opcode;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND_SYNC;
                end
            end
            ST_SEND_SYNC: begin
                if (tx_xfer) begin
                    tx_data_d = opcode_q;
                    state_d   = ST_SEND_OP;
                end
            end
            ST_SEND_OP: begin
                if (tx_xfer) begin
                    if (has_data_q) begin
                        idx_d     = LAST_IDX;
                        tx_data_d = payload_byte(data_q, LAST_IDX);
                        state_d   = ST_SEND_DATA;
                    end else begin
                        tx_data_d = check_q;
                        state_d   = ST_SEND_CHECK;
                    end
                end
            end
            ST_SEND_DATA: begin
                if (tx_xfer) begin
                    check_d = check_q ^ tx_data_q;
                    if (idx_q == 2'd0) begin
                        tx_data_d = check_q ^ tx_data_q;
                        state_d   = ST_SEND_CHECK;
                    end else begin
                        idx_d     = idx_q - 2'd1;
                        tx_data_d = payload_byte(data_q, idx_q - 2'd1);
                    end
                end
            end
            ST_SEND_CHECK: begin
                if (tx_xfer) begin
                    tx_valid_d    = 1'b0;
                    tx_data_d     = 8'h00;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    assign bus.resp_ready = (state_q == ST_IDLE);
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign busy           = (state_q != ST_IDLE);
    assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_response_framer.sv
// tb/tb_response_framer.sv - scoreboard bench for response_framer
module tb_response_framer;
    import response_framer_pkg::*;

    localparam int         DATA_BYTES = 4;
    localparam logic [7:0] SYNC       = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic [15:0] frame_count;

    response_framer_if bus();

    response_framer #(.SYNC_BYTE(SYNC), .DATA_BYTES(DATA_BYTES)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         first;
        bit         last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          sync_cyc[$];
    int          chk_cyc[$];
    logic [15:0] exp_count = 16'h0;
    bit          pending_inc = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    int          tx_mode = 0;
    int          tx_phase = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference frame built straight from the format: SYNC, OPCODE, payload MSB first, XOR check.
    function automatic void push_frame(input logic [7:0] op, input bit has, input logic [31:0] data);
        logic [7:0] bytes[$];
        logic [7:0] x;
        exp_t       t;
        bytes.push_back(SYNC);
        bytes.push_back(op);
        if (has)
            for (int i = DATA_BYTES - 1; i >= 0; i--) bytes.push_back(data[8*i +: 8]);
        x = 8'h00;
        for (int i = 1; i < bytes.size(); i++) x ^= bytes[i];
        bytes.push_back(x);
        for (int i = 0; i < bytes.size(); i++) begin
            t.b     = bytes[i];
            t.first = (i == 0);
            t.last  = (i == bytes.size() - 1);
            exp_q.push_back(t);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (tx_mode)
            0: bus.tx_ready = 1'b1;
            1: begin
                bus.tx_ready = (tx_phase == 0);
                tx_phase = (tx_phase + 1) % 3;
            end
            default: bus.tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a transfer seen here lands on the following rising edge (cycle cyc+1).
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall  = 1'b0;
            pending_inc = 1'b0;
            exp_count   = 16'h0;
        end else begin
            if (pending_inc) begin
                exp_count   = exp_count + 16'd1;
                pending_inc = 1'b0;
            end
            chk("frame_count", {16'h0, frame_count}, {16'h0, exp_count});
            chk("busy_vs_ready", {31'h0, busy}, {31'h0, !bus.resp_ready});
            if (prev_stall) begin
                chk("stall_valid", {31'h0, bus.tx_valid}, 32'h1);
                chk("stall_data", {24'h0, bus.tx_data}, {24'h0, prev_data});
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%h required=none", bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, e.b});
                    if (e.first) sync_cyc.push_back(cyc + 1);
                    if (e.last) begin
                        chk_cyc.push_back(cyc + 1);
                        pending_inc = 1'b1;
                    end
                end
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    task automatic send(input logic [7:0] op, input bit has, input logic [31:0] data, input bit hold);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        bus.resp_opcode   = op;
        bus.resp_has_data = has;
        bus.resp_data     = data;
        bus.resp_valid    = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.resp_ready && reset) begin
                push_frame(op, has, data);
                acc_cyc = cyc + 1;
                done = 1'b1;
            end else if (++n > 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=not_accepted required=accepted");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!hold) begin
            bus.resp_valid    = 1'b0;
            bus.resp_opcode   = 8'($urandom);
            bus.resp_has_data = 1'($urandom_range(0, 1));
            bus.resp_data     = $urandom;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.tx_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.resp_valid    = 1'b0;
        bus.resp_opcode   = 8'h00;
        bus.resp_has_data = 1'b0;
        bus.resp_data     = 32'h0;
        bus.tx_ready      = 1'b1;
        #2;
        chk("rst_resp_ready", {31'h0, bus.resp_ready}, 32'h1);
        chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_frame_count", {16'h0, frame_count}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-frame, just after payload byte 12 goes out.
        tx_mode = 0;
        send(OP_LER_RESULTADO_ALU, 1'b1, 32'h12345678, 1'b0);
        while (cyc < acc_cyc + 3) begin
            @(posedge clk);
            #1;
        end
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("midrst_resp_ready", {31'h0, bus.resp_ready}, 32'h1);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_frame_count", {16'h0, frame_count}, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Data frame with no backpressure: A5 03 12 34 56 78 0B from N+1.
        sync_cyc.delete();
        chk_cyc.delete();
        send(OP_LER_RESULTADO_ALU, 1'b1, 32'h12345678, 1'b0);
        wait_idle();
        chk("data_sync_latency", sync_cyc.size() > 0 ? sync_cyc[0] : -1, acc_cyc + 1);
        chk("data_check_cycle", chk_cyc.size() > 0 ? chk_cyc[0] : -1, acc_cyc + 7);
        @(negedge clk);
        chk("data_frame_count", {16'h0, frame_count}, 32'h1);

        // Opcode-only ack: A5 02 02.
        chk_cyc.delete();
        @(posedge clk);
        #1;
        send(OP_RESET_PROCESSADOR, 1'b0, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        chk("ack_check_cycle", chk_cyc.size() > 0 ? chk_cyc[0] : -1, acc_cyc + 3);
        @(negedge clk);
        chk("ack_busy", {31'h0, busy}, 32'h0);
        chk("ack_resp_ready", {31'h0, bus.resp_ready}, 32'h1);

        // Backpressure pattern 1,0,0 repeating.
        @(posedge clk);
        #1;
        tx_mode = 1;
        send(OP_LER_RESULTADO_ALU, 1'b1, 32'h12345678, 1'b0);
        wait_idle();
        tx_mode = 0;

        // Back-to-back with resp_valid held high.
        @(posedge clk);
        #1;
        sync_cyc.delete();
        chk_cyc.delete();
        send(OP_LER_REGISTRADOR, 1'b1, 32'hDEADBEEF, 1'b1);
        send(OP_LER_MEMORIA, 1'b1, 32'h0000_0000, 1'b0);
        wait_idle();
        chk("b2b_frame1_len", (chk_cyc.size() > 0 && sync_cyc.size() > 0) ? chk_cyc[0] - sync_cyc[0] : -1, 6);
        chk("b2b_gap", (chk_cyc.size() > 0 && sync_cyc.size() > 1) ? sync_cyc[1] - chk_cyc[0] : -1, 2);
        chk("b2b_frame2_len", (chk_cyc.size() > 1 && sync_cyc.size() > 1) ? chk_cyc[1] - sync_cyc[1] : -1, 6);

        // Randomized traffic under random backpressure.
        for (int k = 0; k < 40; k++) begin
            tx_mode = $urandom_range(0, 2);
            send(8'($urandom), 1'($urandom_range(0, 1)), $urandom, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        tx_mode = 0;

        // Counter wrap.
        @(posedge clk);
        #1;
        force dut.frame_count_q = 16'hFFFE;
        exp_count = 16'hFFFE;
        @(negedge clk);
        #1;
        release dut.frame_count_q;
        @(posedge clk);
        #1;
        send(OP_ESCREVER_UART, 1'b0, 32'h0, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("wrap_ffff", {16'h0, frame_count}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        send(OP_ESCREVER_MEMORIA, 1'b0, 32'h0, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("wrap_zero", {16'h0, frame_count}, 32'h0);

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
